div_arbiter: RTL

DIV_ARBITER -- requirements
Module: div_arbiter

---
 rtl/div_arb_pkg.sv | 26 ++
 rtl/div_arbiter_rr_pick.sv | 35 +++
 rtl/div_arbiter.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/div_arb_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : div_arb_pkg
// Purpose  : Shared state encoding, default sizing and id-width helper for
//            the divider arbiter.
// Revision : 1.0
// ============================================================================
package div_arb_pkg;

  localparam int DEF_NREQ = 4;
  localparam int DEF_W    = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  function automatic int id_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/div_arbiter_rr_pick.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Purpose  : Circular first-set search of a request vector starting at ptr.
// Revision : 1.0
// ============================================================================
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IDW-1:0]  i_ptr,
  output logic [IDW-1:0]  o_grant,
  output logic            o_any
);

  int w_idx;

  // Scan from the farthest offset back to ptr so the nearest hit is written last.
  always_comb begin
    o_grant = '0;
    o_any   = 1'b0;
    w_idx   = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_idx = (int'(i_ptr) + k) % NREQ;
      if (i_req[w_idx]) begin
        o_grant = IDW'(w_idx);
        o_any   = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/div_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : div_arbiter
// Purpose  : Round-robin arbiter sharing one iterative divider among NREQ
//            requesters. Optional macro DIV_ARB_DVZ_BYPASS_EN answers zero
//            divisors directly without starting the divider.
// Revision : 1.0
// ============================================================================
module div_arbiter
  import div_arb_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int W    = DEF_W,
  localparam int IDW = id_width(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic              rsp_valid,
  output logic [IDW-1:0]    rsp_id,
  output logic [W-1:0]      rsp_q,
  output logic              rsp_ov,
  output logic              rsp_dvz,
  output logic              div_start,
  output logic [W-1:0]      div_a,
  output logic [W-1:0]      div_b,
  input  logic [W-1:0]      div_q,
  input  logic              div_busy,
  input  logic              div_valid,
  input  logic              div_ov,
  input  logic              div_dvz
);

  state_t         r_state;
  state_t         w_next;
  logic [IDW-1:0] r_ptr;
  logic [IDW-1:0] r_id;
  logic [IDW-1:0] w_grant;
  logic           w_any;
  logic [W-1:0]   r_a;
  logic [W-1:0]   r_b;
  logic [W-1:0]   w_sel_a;
  logic [W-1:0]   w_sel_b;
  logic           r_first;
  logic [IDW-1:0] r_rsp_id;
  logic [W-1:0]   r_rsp_q;
  logic           r_rsp_ov;
  logic           r_rsp_dvz;
  logic           w_accept;
  logic           w_capture;
  logic           w_bypass;

  rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr_pick (
    .i_req   (req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_any   (w_any)
  );

  assign w_sel_a   = req_a[w_grant*W +: W];
  assign w_sel_b   = req_b[w_grant*W +: W];
  assign w_accept  = (r_state == ST_IDLE) && w_any && !rst;
  // r_first masks a valid left over from the previous divide.
  assign w_capture = (r_state == ST_WAIT) && !r_first && div_valid && !div_busy;

`ifdef DIV_ARB_DVZ_BYPASS_EN
  assign w_bypass = (w_sel_b == '0);
`else
  assign w_bypass = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    req_ready = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          req_ready[w_grant] = 1'b1;
          w_next = w_bypass ? ST_RESP : ST_ISSUE;
        end
      end
      ST_ISSUE: w_next = ST_WAIT;
      ST_WAIT:  if (w_capture) w_next = ST_RESP;
      ST_RESP:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr     <= '0;
      r_id      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_first   <= 1'b0;
      r_rsp_id  <= '0;
      r_rsp_q   <= '0;
      r_rsp_ov  <= 1'b0;
      r_rsp_dvz <= 1'b0;
    end else begin
      r_first <= (r_state == ST_ISSUE);
      if (w_accept) begin
        r_id <= w_grant;
        r_a  <= w_sel_a;
        r_b  <= w_sel_b;
        if (w_bypass) begin
          r_rsp_id  <= w_grant;
          r_rsp_q   <= '0;
          r_rsp_ov  <= 1'b0;
          r_rsp_dvz <= 1'b1;
        end
      end
      if (w_capture) begin
        r_rsp_id  <= r_id;
        r_rsp_q   <= div_q;
        r_rsp_ov  <= div_ov;
        r_rsp_dvz <= div_dvz;
      end
      if (r_state == ST_RESP)
        r_ptr <= (r_id == IDW'(NREQ - 1)) ? '0 : r_id + 1'b1;
    end
  end

  assign div_start = (r_state == ST_ISSUE);
  assign div_a     = r_a;
  assign div_b     = r_b;
  assign rsp_valid = (r_state == ST_RESP);
  assign rsp_id    = r_rsp_id;
  assign rsp_q     = r_rsp_q;
  assign rsp_ov    = r_rsp_ov;
  assign rsp_dvz   = r_rsp_dvz;

endmodule
`default_nettype wire
